trees_job_sequencer: RTL and testbench
======================================

Name: trees_job_sequencer

Overview:
Sequences the tree-ensemble accelerator through one inference job. A job may hold more samples than one accelerator burst can take, so the block splits it into bursts of at most MAX_BURST samples. For each burst it drives the accelerator configuration, pulses conf_done and waits for acc_done. It also publishes per-burst DMA word offsets for the address-translation stage. It sits between the host register file and the accelerator config/status pins.

Parameters:
MAX_BURST, 5000, maximum samples per accelerator burst
N_FEATURE, 32, maximum legal n_features per sample

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
job_valid  in  1  job request
job_ready  out  1  sequencer can accept a job
job_load_trees  in  1  job is a tree-memory load, not inference
job_n_samples  in  32  total samples in job
job_n_features  in  32  features per sample
job_feat_base  in  32  feature-region base, 64-bit words
job_pred_base  in  32  prediction-region base, 64-bit words
timeout_cycles  in  32  WAIT_DONE watchdog limit; 0 disables it
acc_load_trees  out  32  to accelerator load_trees; bit0 = job_load_trees, other bits 0
acc_n_features  out  32  to accelerator n_features
acc_burst_len  out  32  to accelerator burst_len
acc_conf_done  out  1  one-cycle start pulse to accelerator
acc_done  in  1  accelerator completion pulse
burst_feat_offset  out  32  feature DMA base for the current burst
burst_pred_offset  out  32  prediction DMA base for the current burst
bursts_done  out  32  bursts completed in current/last job
busy  out  1  high in any state except IDLE
job_done  out  1  one-cycle success pulse
job_error  out  1  one-cycle error pulse (bad config or timeout)

Behaviour:
- Reset values: all outputs 0 except job_ready=1. FSM goes to IDLE. Counters, offsets and latched job fields are cleared.
- FSM states: IDLE, CHECK, CONF, WAIT_DONE, ADVANCE, FINISH, FAIL.
- IDLE
  - job_ready=1.
  - On job_valid&&job_ready, latch all job_* fields and go to CHECK.
  - Latch remaining=n_samples, feat_acc=0, pred_acc=0, bursts_done=0.
- CHECK (1 cycle)
  - If load_trees=0 and (n_features==0 or n_features>N_FEATURE): go to FAIL.
  - Else if load_trees=0 and n_samples==0: go to FINISH; no conf pulse is issued.
  - Else go to CONF.
- CONF (1 cycle)
  - acc_conf_done=1.
  - acc_burst_len = load_trees ? 0 : min(remaining, MAX_BURST).
  - acc_load_trees, acc_n_features, acc_burst_len and both offsets are registered on CONF entry. They stay stable until the next CONF.
  - Go to WAIT_DONE and clear the watchdog.
- WAIT_DONE
  - Watchdog increments each cycle.
  - On acc_done: go to ADVANCE.
  - Else if timeout_cycles!=0 and watchdog==timeout_cycles-1: go to FAIL.
  - acc_done wins when both occur in the same cycle.
- ADVANCE (1 cycle)
  - bursts_done+1.
  - If load_trees: remaining forced to 0.
  - Else:
    - remaining -= burst_len
    - feat_acc += (burst_len*n_features+1)>>1
    - pred_acc += (burst_len+7)>>3
  - remaining==0: go to FINISH. Otherwise go to CONF.
- FINISH: job_done=1 for 1 cycle, then IDLE.
- FAIL: job_error=1 for 1 cycle, then IDLE. The accelerator is not reset; software must reset it after a timeout.
- Offset outputs:
  - burst_feat_offset = job_feat_base + feat_acc.
  - burst_pred_offset = job_pred_base + pred_acc.
  - Software lays out each burst's data padded to these per-burst ceilings.
- Arithmetic: all 32-bit unsigned. Products truncate to 32 bits and sums wrap modulo 2^32; no overflow detection.
- acc_done outside WAIT_DONE is ignored.
- job_valid outside IDLE is ignored (job_ready=0).
- Reset mid-job returns immediately to reset values; no done/error pulse is emitted.
- Latency:
  - Acceptance cycle T gives acc_conf_done at T+2.
  - acc_done at cycle D gives the next conf pulse at D+2, or job_done at D+2.

Decomposition:
- Package trees_seq_pkg holds:
  - the seq_state_e enum;
  - functions feat_words(len,nf) and pred_words(len);
  - constant WORD_BITS=64.
- Sub-module trees_watchdog holds the counter, clear, enable, limit compare, and a zero-limit disable that yields the expire output.

Test Plan:
1. n_samples=12000, n_features=10, MAX_BURST=5000, bases 0 -> three conf pulses.
   - burst_len 5000, 5000, 2000.
   - feat offsets 0, 25000, 50000.
   - pred offsets 0, 625, 1250.
   - job_done 2 cycles after the third acc_done; bursts_done=3.
2. load_trees=1, n_samples=999 -> exactly one conf pulse with acc_load_trees=1 and acc_burst_len=0; job_done after acc_done.
3. n_samples=3, n_features=3, feat_base=100, pred_base=7 -> burst_len 3, burst_feat_offset 100, burst_pred_offset 7; internal words advance by 5 and 1.
4. n_samples=0 -> no acc_conf_done, job_done at T+2. n_features=0 or 33 -> job_error at T+2, no conf.
5. timeout_cycles=100, acc_done withheld:
   - job_error 100 cycles after WAIT_DONE entry, then job_ready=1.
   - Repeat with acc_done on the expiry cycle -> ADVANCE, no error.
6. Reset asserted during WAIT_DONE of burst 2 -> all outputs at reset values. A later stray acc_done in IDLE causes no pulse and no state change.

Source files
------------

// File: rtl/trees_seq_pkg.sv
// Shared types and word-count helpers for the tree-ensemble job sequencer.
// DMA offsets count 64-bit words; each burst is padded to whole words.
package trees_seq_pkg;

  localparam int WORD_BITS = 64;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    CONF,
    WAIT_DONE,
    ADVANCE,
    FINISH,
    FAIL
  } seq_state_e;

  // Features are 32-bit, so two of them share one 64-bit word.
  function automatic logic [31:0] feat_words(input logic [31:0] len, input logic [31:0] nf);
    logic [31:0] prod;
    prod = len * nf;
    return (prod + 32'd1) >> 1;
  endfunction

  // Predictions are 8-bit, so eight of them share one 64-bit word.
  function automatic logic [31:0] pred_words(input logic [31:0] len);
    return (len + 32'd7) >> 3;
  endfunction

endpackage

// File: rtl/trees_watchdog.sv
// Cycle watchdog for the accelerator wait state; a zero limit never expires.
module trees_watchdog (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] limit,
  output logic        expire
);

  logic [31:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign expire = enable && (limit != 32'd0) && (count_reg == limit - 32'd1);

endmodule

// File: rtl/trees_job_sequencer.sv
// Splits an inference job into accelerator bursts, drives the accelerator
// config pins per burst and publishes per-burst DMA word offsets.
module trees_job_sequencer
  import trees_seq_pkg::*;
#(
  parameter int unsigned MAX_BURST = 5000,
  parameter int unsigned N_FEATURE = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic        job_load_trees,
  input  logic [31:0] job_n_samples,
  input  logic [31:0] job_n_features,
  input  logic [31:0] job_feat_base,
  input  logic [31:0] job_pred_base,
  input  logic [31:0] timeout_cycles,
  output logic [31:0] acc_load_trees,
  output logic [31:0] acc_n_features,
  output logic [31:0] acc_burst_len,
  output logic        acc_conf_done,
  input  logic        acc_done,
  output logic [31:0] burst_feat_offset,
  output logic [31:0] burst_pred_offset,
  output logic [31:0] bursts_done,
  output logic        busy,
  output logic        job_done,
  output logic        job_error
);

  seq_state_e  state;
  logic        lt_reg;
  logic [31:0] nf_reg;
  logic [31:0] feat_base_reg;
  logic [31:0] pred_base_reg;
  logic [31:0] remaining_reg;
  logic [31:0] feat_acc_reg;
  logic [31:0] pred_acc_reg;

  logic        wd_expire;
  logic        bad_cfg;
  logic        empty_job;
  logic        enter_conf;
  logic [31:0] rem_adv;
  logic [31:0] feat_adv;
  logic [31:0] pred_adv;
  logic [31:0] conf_rem;
  logic [31:0] conf_feat;
  logic [31:0] conf_pred;
  logic [31:0] conf_len;

  trees_watchdog u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == CONF),
    .enable (state == WAIT_DONE),
    .limit  (timeout_cycles),
    .expire (wd_expire)
  );

  // A tree load runs with burst_len 0, so the accumulators see zero increments.
  always_comb begin
    bad_cfg   = !lt_reg && ((nf_reg == 32'd0) || (nf_reg > 32'(N_FEATURE)));
    empty_job = !lt_reg && (remaining_reg == 32'd0);
    rem_adv   = lt_reg ? 32'd0 : remaining_reg - acc_burst_len;
    feat_adv  = feat_acc_reg + feat_words(acc_burst_len, nf_reg);
    pred_adv  = pred_acc_reg + pred_words(acc_burst_len);

    conf_rem  = remaining_reg;
    conf_feat = feat_acc_reg;
    conf_pred = pred_acc_reg;
    if (state == ADVANCE) begin
      conf_rem  = rem_adv;
      conf_feat = feat_adv;
      conf_pred = pred_adv;
    end

    conf_len = conf_rem;
    if (lt_reg) begin
      conf_len = 32'd0;
    end else if (conf_rem > 32'(MAX_BURST)) begin
      conf_len = 32'(MAX_BURST);
    end

    enter_conf = ((state == CHECK) && !bad_cfg && !empty_job) ||
                 ((state == ADVANCE) && (rem_adv != 32'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      lt_reg            <= 1'b0;
      nf_reg            <= '0;
      feat_base_reg     <= '0;
      pred_base_reg     <= '0;
      remaining_reg     <= '0;
      feat_acc_reg      <= '0;
      pred_acc_reg      <= '0;
      job_ready         <= 1'b1;
      acc_load_trees    <= '0;
      acc_n_features    <= '0;
      acc_burst_len     <= '0;
      acc_conf_done     <= 1'b0;
      burst_feat_offset <= '0;
      burst_pred_offset <= '0;
      bursts_done       <= '0;
      busy              <= 1'b0;
      job_done          <= 1'b0;
      job_error         <= 1'b0;
    end else begin
      acc_conf_done <= 1'b0;
      job_done      <= 1'b0;
      job_error     <= 1'b0;

      case (state)
        IDLE: begin
          if (job_valid && job_ready) begin
            lt_reg        <= job_load_trees;
            nf_reg        <= job_n_features;
            feat_base_reg <= job_feat_base;
            pred_base_reg <= job_pred_base;
            remaining_reg <= job_n_samples;
            feat_acc_reg  <= '0;
            pred_acc_reg  <= '0;
            bursts_done   <= '0;
            job_ready     <= 1'b0;
            busy          <= 1'b1;
            state         <= CHECK;
          end
        end
        CHECK: begin
          if (bad_cfg) begin
            job_error <= 1'b1;
            state     <= FAIL;
          end else if (empty_job) begin
            job_done <= 1'b1;
            state    <= FINISH;
          end else begin
            state <= CONF;
          end
        end
        CONF: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (acc_done) begin
            state <= ADVANCE;
          end else if (wd_expire) begin
            job_error <= 1'b1;
            state     <= FAIL;
          end
        end
        ADVANCE: begin
          bursts_done   <= bursts_done + 32'd1;
          remaining_reg <= rem_adv;
          feat_acc_reg  <= feat_adv;
          pred_acc_reg  <= pred_adv;
          if (rem_adv == 32'd0) begin
            job_done <= 1'b1;
            state    <= FINISH;
          end else begin
            state <= CONF;
          end
        end
        FINISH, FAIL: begin
          job_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Accelerator config and offsets are captured on the edge entering CONF.
      if (enter_conf) begin
        acc_conf_done     <= 1'b1;
        acc_load_trees    <= {31'd0, lt_reg};
        acc_n_features    <= nf_reg;
        acc_burst_len     <= conf_len;
        burst_feat_offset <= feat_base_reg + conf_feat;
        burst_pred_offset <= pred_base_reg + conf_pred;
      end
    end
  end

endmodule

// File: tb/tb_trees_job_sequencer.sv
// Scoreboard bench: stimulus pushes expected conf/end events with their cycle,
// a negedge monitor pops and compares whenever the sequencer pulses.
module tb_trees_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic        job_load_trees;
  logic [31:0] job_n_samples;
  logic [31:0] job_n_features;
  logic [31:0] job_feat_base;
  logic [31:0] job_pred_base;
  logic [31:0] timeout_cycles;
  logic [31:0] acc_load_trees;
  logic [31:0] acc_n_features;
  logic [31:0] acc_burst_len;
  logic        acc_conf_done;
  logic        acc_done;
  logic [31:0] burst_feat_offset;
  logic [31:0] burst_pred_offset;
  logic [31:0] bursts_done;
  logic        busy;
  logic        job_done;
  logic        job_error;

  trees_job_sequencer #(.MAX_BURST(5000), .N_FEATURE(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_load_trees    (job_load_trees),
    .job_n_samples     (job_n_samples),
    .job_n_features    (job_n_features),
    .job_feat_base     (job_feat_base),
    .job_pred_base     (job_pred_base),
    .timeout_cycles    (timeout_cycles),
    .acc_load_trees    (acc_load_trees),
    .acc_n_features    (acc_n_features),
    .acc_burst_len     (acc_burst_len),
    .acc_conf_done     (acc_conf_done),
    .acc_done          (acc_done),
    .burst_feat_offset (burst_feat_offset),
    .burst_pred_offset (burst_pred_offset),
    .bursts_done       (bursts_done),
    .busy              (busy),
    .job_done          (job_done),
    .job_error         (job_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] lt;
    logic [31:0] nf;
    logic [31:0] blen;
    logic [31:0] foff;
    logic [31:0] poff;
    int          at;
  } conf_t;

  typedef struct {
    logic        err;
    logic [31:0] bursts;
    int          at;
  } end_t;

  conf_t conf_q[$];
  end_t  end_q[$];
  conf_t ce;
  end_t  ee;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one line per observed transaction, compared against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_conf_done) begin
        $display("conf  cyc=%0d lt=%0d nf=%0d len=%0d foff=%0d poff=%0d", cyc,
                 acc_load_trees, acc_n_features, acc_burst_len, burst_feat_offset, burst_pred_offset);
        if (conf_q.size() == 0) begin
          check("unexpected_conf", {31'd0, acc_conf_done}, 32'd0);
        end else begin
          ce = conf_q.pop_front();
          check("conf_cycle", cyc, ce.at);
          check("conf_load_trees", acc_load_trees, ce.lt);
          check("conf_n_features", acc_n_features, ce.nf);
          check("conf_burst_len", acc_burst_len, ce.blen);
          check("conf_feat_offset", burst_feat_offset, ce.foff);
          check("conf_pred_offset", burst_pred_offset, ce.poff);
        end
      end
      if (job_done || job_error) begin
        $display("end   cyc=%0d done=%0d error=%0d bursts=%0d", cyc, job_done, job_error, bursts_done);
        if (end_q.size() == 0) begin
          check("unexpected_end", {31'd0, job_done | job_error}, 32'd0);
        end else begin
          ee = end_q.pop_front();
          check("end_cycle", cyc, ee.at);
          check("end_error", {31'd0, job_error}, {31'd0, ee.err});
          check("end_done", {31'd0, job_done}, {31'd0, ~ee.err});
          check("end_bursts", bursts_done, ee.bursts);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, {31'd0, job_ready}, 32'd1);
    check({tag, "_acc_load_trees"}, acc_load_trees, 32'd0);
    check({tag, "_acc_n_features"}, acc_n_features, 32'd0);
    check({tag, "_acc_burst_len"}, acc_burst_len, 32'd0);
    check({tag, "_acc_conf_done"}, {31'd0, acc_conf_done}, 32'd0);
    check({tag, "_feat_offset"}, burst_feat_offset, 32'd0);
    check({tag, "_pred_offset"}, burst_pred_offset, 32'd0);
    check({tag, "_bursts_done"}, bursts_done, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_job_done"}, {31'd0, job_done}, 32'd0);
    check({tag, "_job_error"}, {31'd0, job_error}, 32'd0);
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send_job(input logic lt, input logic [31:0] ns, input logic [31:0] nf,
                          input logic [31:0] fb, input logic [31:0] pb, output int t);
    for (int i = 0; i < 50 && !job_ready; i++) step();
    check("job_ready_before_send", {31'd0, job_ready}, 32'd1);
    job_load_trees = lt;
    job_n_samples  = ns;
    job_n_features = nf;
    job_feat_base  = fb;
    job_pred_base  = pb;
    job_valid      = 1'b1;
    t = cyc;
    step();
    job_valid = 1'b0;
  endtask

  task automatic wait_conf();
    for (int i = 0; i < 300 && !acc_conf_done; i++) step();
    if (!acc_conf_done) check("conf_timeout", {31'd0, acc_conf_done}, 32'd1);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 300 && !(job_done || job_error); i++) step();
    if (!(job_done || job_error)) check("end_timeout", {31'd0, job_done | job_error}, 32'd1);
    step();
  endtask

  task automatic pulse_done(output int d);
    acc_done = 1'b1;
    d = cyc;
    step();
    acc_done = 1'b0;
  endtask

  task automatic push_conf(input logic lt, input logic [31:0] nf, input logic [31:0] blen,
                           input logic [31:0] foff, input logic [31:0] poff, input int at);
    conf_t c;
    c.lt = {31'd0, lt}; c.nf = nf; c.blen = blen; c.foff = foff; c.poff = poff; c.at = at;
    conf_q.push_back(c);
  endtask

  task automatic push_end(input logic err, input logic [31:0] bursts, input int at);
    end_t e;
    e.err = err; e.bursts = bursts; e.at = at;
    end_q.push_back(e);
  endtask

  // Multi-burst job with the accelerator answering 2 cycles after each conf.
  task automatic run_job(input logic lt, input logic [31:0] ns, input logic [31:0] nf,
                         input logic [31:0] fb, input logic [31:0] pb, input int nb,
                         input logic [31:0] lens[3], input logic [31:0] foffs[3],
                         input logic [31:0] poffs[3]);
    int t, d;
    send_job(lt, ns, nf, fb, pb, t);
    push_conf(lt, nf, lens[0], foffs[0], poffs[0], t + 2);
    for (int b = 0; b < nb; b++) begin
      wait_conf();
      step();
      step();
      pulse_done(d);
      if (b < nb - 1) push_conf(lt, nf, lens[b+1], foffs[b+1], poffs[b+1], d + 2);
      else push_end(1'b0, nb, d + 2);
    end
    wait_end();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t, d;
    rst_n          = 1'b0;
    job_valid      = 1'b0;
    job_load_trees = 1'b0;
    job_n_samples  = '0;
    job_n_features = '0;
    job_feat_base  = '0;
    job_pred_base  = '0;
    timeout_cycles = '0;
    acc_done       = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // 12000 samples x 10 features: three bursts.
    run_job(1'b0, 32'd12000, 32'd10, 32'd0, 32'd0, 3,
            '{32'd5000, 32'd5000, 32'd2000}, '{32'd0, 32'd25000, 32'd50000},
            '{32'd0, 32'd625, 32'd1250});

    // Tree load: one conf, burst_len 0.
    run_job(1'b1, 32'd999, 32'd7, 32'd0, 32'd0, 1,
            '{32'd0, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0});

    // Small job with nonzero bases.
    run_job(1'b0, 32'd3, 32'd3, 32'd100, 32'd7, 1,
            '{32'd3, 32'd0, 32'd0}, '{32'd100, 32'd0, 32'd0}, '{32'd7, 32'd0, 32'd0});

    // Two bursts with bases: second offsets 100+7500, 7+625.
    run_job(1'b0, 32'd5003, 32'd3, 32'd100, 32'd7, 2,
            '{32'd5000, 32'd3, 32'd0}, '{32'd100, 32'd7600, 32'd0}, '{32'd7, 32'd632, 32'd0});

    // Empty job and illegal feature counts.
    send_job(1'b0, 32'd0, 32'd10, 32'd0, 32'd0, t);
    push_end(1'b0, 32'd0, t + 2);
    wait_end();
    send_job(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, t);
    push_end(1'b1, 32'd0, t + 2);
    wait_end();
    send_job(1'b0, 32'd5, 32'd33, 32'd0, 32'd0, t);
    push_end(1'b1, 32'd0, t + 2);
    wait_end();

    // Watchdog expiry: WAIT_DONE entered at t+3, error 100 cycles later.
    timeout_cycles = 32'd100;
    send_job(1'b0, 32'd10, 32'd4, 32'd0, 32'd0, t);
    push_conf(1'b0, 32'd4, 32'd10, 32'd0, 32'd0, t + 2);
    push_end(1'b1, 32'd0, t + 103);
    wait_end();
    check("ready_after_timeout", {31'd0, job_ready}, 32'd1);

    // acc_done on the expiry cycle wins.
    send_job(1'b0, 32'd10, 32'd4, 32'd0, 32'd0, t);
    push_conf(1'b0, 32'd4, 32'd10, 32'd0, 32'd0, t + 2);
    wait_conf();
    repeat (100) step();
    pulse_done(d);
    check("done_on_expiry_cycle", d, t + 102);
    push_end(1'b0, 32'd1, d + 2);
    wait_end();
    timeout_cycles = 32'd0;

    // Reset during WAIT_DONE of burst 2.
    send_job(1'b0, 32'd12000, 32'd10, 32'd0, 32'd0, t);
    push_conf(1'b0, 32'd10, 32'd5000, 32'd0, 32'd0, t + 2);
    wait_conf();
    step();
    step();
    pulse_done(d);
    push_conf(1'b0, 32'd10, 32'd5000, 32'd25000, 32'd625, d + 2);
    wait_conf();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_reset_outputs("after_reset");
    pulse_done(d);
    repeat (4) step();
    check("stray_done_busy", {31'd0, busy}, 32'd0);
    check("stray_done_ready", {31'd0, job_ready}, 32'd1);
    check("stray_done_bursts", bursts_done, 32'd0);

    check("conf_queue_empty", conf_q.size(), 32'd0);
    check("end_queue_empty", end_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
